// File: rtl/keyboard_ps2_receiver.sv
// PS/2 device-to-host frame receiver: de-glitches the synchronized PS/2 clock, shifts in
// 11-bit frames and hands good scancodes to a single-entry valid/ack buffer.
module keyboard_ps2_receiver #(
    parameter int P_FILTER  = 8,
    parameter int P_TIMEOUT = 100000
) (
    input  logic       iCLOCK,
    input  logic       iRESET,
    input  logic       iRESET_SYNC,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic       oVALID,
    output logic [7:0] oDATA,
    input  logic       iACK,
    output logic       oPARITY_ERR,
    output logic       oFRAME_ERR,
    output logic       oOVERRUN
);

    localparam int CW = $clog2(P_FILTER);
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(P_FILTER - 1);
    localparam logic [TW-1:0] TMAX     = TW'(P_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state;
    logic            fclk;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic            fall_event;

    // The filtered clock drops on exactly this edge, so the data line is sampled here too.
    assign fall_event = fclk && !iPS2_CLK && (cnt == FILT_MAX);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            fclk <= 1'b1;
            cnt  <= '0;
        end else if (iRESET_SYNC) begin
            fclk <= 1'b1;
            cnt  <= '0;
        end else if (iPS2_CLK != fclk) begin
            if (cnt == FILT_MAX) begin
                fclk <= iPS2_CLK;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            oVALID      <= 1'b0;
            oDATA       <= '0;
            oPARITY_ERR <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oOVERRUN    <= 1'b0;
        end else if (iRESET_SYNC) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            oVALID      <= 1'b0;
            oDATA       <= '0;
            oPARITY_ERR <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oOVERRUN    <= 1'b0;
        end else begin
            oPARITY_ERR <= 1'b0;
            oFRAME_ERR  <= 1'b0;
            oOVERRUN    <= 1'b0;

            if (iACK && oVALID) begin
                oVALID <= 1'b0;
            end

            // Timeout outranks a coincident fall event; that edge is dropped entirely.
            if (state != ST_IDLE && tcnt == TMAX) begin
                state      <= ST_IDLE;
                tcnt       <= '0;
                oFRAME_ERR <= 1'b1;
            end else begin
                if (state == ST_IDLE || fall_event) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (fall_event && !iPS2_DAT) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (fall_event) begin
                            shift_reg <= {iPS2_DAT, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (fall_event) begin
                            parity_bit <= iPS2_DAT;
                            state      <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (fall_event) begin
                            state <= ST_IDLE;
                            if (!iPS2_DAT) begin
                                oFRAME_ERR <= 1'b1;
                            end else if (^{shift_reg, parity_bit} == 1'b0) begin
                                oPARITY_ERR <= 1'b1;
                            end else begin
                                oDATA    <= shift_reg;
                                oVALID   <= 1'b1;
                                oOVERRUN <= oVALID && !iACK;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keyboard_ps2_receiver.sv
// Scenario bench for keyboard_ps2_receiver: drives PS/2 frames bit by bit and checks each
// outcome against a scoreboard filled from a small valid/ack buffer model.
module tb_keyboard_ps2_receiver;

    localparam int P_FILTER  = 4;
    localparam int P_TIMEOUT = 200;
    localparam int HALF      = 20;

    logic       iCLOCK = 1'b0;
    logic       iRESET;
    logic       iRESET_SYNC;
    logic       iPS2_CLK;
    logic       iPS2_DAT;
    logic       iACK;
    logic       oVALID;
    logic [7:0] oDATA;
    logic       oPARITY_ERR;
    logic       oFRAME_ERR;
    logic       oOVERRUN;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } res_t;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       perr2;
        logic       ferr2;
        logic       ovr2;
    } obs_t;

    res_t       exp_q[$];
    logic       model_valid = 1'b0;
    logic [7:0] model_data  = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         perr_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;

    keyboard_ps2_receiver #(
        .P_FILTER (P_FILTER),
        .P_TIMEOUT(P_TIMEOUT)
    ) dut (
        .iCLOCK     (iCLOCK),
        .iRESET     (iRESET),
        .iRESET_SYNC(iRESET_SYNC),
        .iPS2_CLK   (iPS2_CLK),
        .iPS2_DAT   (iPS2_DAT),
        .oVALID     (oVALID),
        .oDATA      (oDATA),
        .iACK       (iACK),
        .oPARITY_ERR(oPARITY_ERR),
        .oFRAME_ERR (oFRAME_ERR),
        .oOVERRUN   (oOVERRUN)
    );

    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) cyc <= cyc + 1;

    // Pulse tallies let scenarios prove that exactly one (or no) pulse occurred in a window.
    always @(negedge iCLOCK) begin
        if (oPARITY_ERR) perr_cnt <= perr_cnt + 1;
        if (oFRAME_ERR)  ferr_cnt <= ferr_cnt + 1;
        if (oOVERRUN)    ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic ps2_bit(input logic b, input logic ack_stop, output obs_t o);
        @(negedge iCLOCK);
        iPS2_DAT = b;
        repeat (HALF - 1) @(negedge iCLOCK);
        iPS2_CLK = 1'b0;
        repeat (P_FILTER - 1) @(posedge iCLOCK);
        if (ack_stop) begin
            @(negedge iCLOCK);
            iACK = 1'b1;
        end
        @(posedge iCLOCK);
        @(negedge iCLOCK);
        iACK = 1'b0;
        last_fall_cyc = cyc;
        o.valid = oVALID;
        o.data  = oDATA;
        o.perr  = oPARITY_ERR;
        o.ferr  = oFRAME_ERR;
        o.ovr   = oOVERRUN;
        @(negedge iCLOCK);
        o.perr2 = oPARITY_ERR;
        o.ferr2 = oFRAME_ERR;
        o.ovr2  = oOVERRUN;
        repeat (HALF - 2) @(negedge iCLOCK);
        iPS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input logic ack_stop, output obs_t o);
        obs_t dummy;
        res_t e;
        logic par;
        par     = ~(^d) ^ par_flip;
        e.valid = model_valid;
        e.data  = model_data;
        e.perr  = 1'b0;
        e.ferr  = 1'b0;
        e.ovr   = 1'b0;
        if (!stop) begin
            e.ferr = 1'b1;
        end else if (par_flip) begin
            e.perr = 1'b1;
        end else begin
            e.ovr       = model_valid & ~ack_stop;
            e.valid     = 1'b1;
            e.data      = d;
            model_valid = 1'b1;
            model_data  = d;
        end
        exp_q.push_back(e);
        ps2_bit(1'b0, 1'b0, dummy);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0, dummy);
        ps2_bit(par, 1'b0, dummy);
        ps2_bit(stop, ack_stop, o);
    endtask

    task automatic do_ack();
        @(negedge iCLOCK);
        iACK = 1'b1;
        @(negedge iCLOCK);
        iACK = 1'b0;
        model_valid = 1'b0;
    endtask

    task automatic test_reset();
        iRESET = 1'b1; iRESET_SYNC = 1'b0; iPS2_CLK = 1'b1; iPS2_DAT = 1'b1; iACK = 1'b0;
        #12;
        checks++; if (oVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", oVALID); end
        checks++; if (oDATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", oDATA); end
        checks++; if ({oPARITY_ERR, oFRAME_ERR, oOVERRUN} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000", {oPARITY_ERR, oFRAME_ERR, oOVERRUN}); end
        @(negedge iCLOCK);
        iRESET = 1'b0;
        repeat (HALF) @(negedge iCLOCK);
    endtask

    task automatic test_receive_ack();
        obs_t o;
        res_t e;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.valid !== e.valid) begin errors++; $display("[TB] FAIL rx_valid: got %b expected %b", o.valid, e.valid); end
        checks++; if (o.data !== e.data) begin errors++; $display("[TB] FAIL rx_data: got %h expected %h", o.data, e.data); end
        checks++; if ({o.perr, o.ferr, o.ovr} !== {e.perr, e.ferr, e.ovr}) begin errors++; $display("[TB] FAIL rx_pulses: got %b expected %b", {o.perr, o.ferr, o.ovr}, {e.perr, e.ferr, e.ovr}); end
        do_ack();
        checks++; if (oVALID !== model_valid) begin errors++; $display("[TB] FAIL ack_valid: got %b expected %b", oVALID, model_valid); end
        checks++; if (oDATA !== model_data) begin errors++; $display("[TB] FAIL ack_data_hold: got %h expected %h", oDATA, model_data); end
    endtask

    task automatic test_parity_error();
        obs_t o;
        res_t e;
        int   p0;
        p0 = perr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.perr !== e.perr) begin errors++; $display("[TB] FAIL parity_pulse: got %b expected %b", o.perr, e.perr); end
        checks++; if (o.perr2 !== 1'b0) begin errors++; $display("[TB] FAIL parity_one_cycle: got %b expected 0", o.perr2); end
        checks++; if (o.valid !== e.valid) begin errors++; $display("[TB] FAIL parity_valid: got %b expected %b", o.valid, e.valid); end
        checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("[TB] FAIL parity_count: got %0d expected 1", perr_cnt - p0); end
    endtask

    task automatic test_frame_error();
        obs_t o;
        res_t e;
        int   f0;
        f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if (o.ferr !== e.ferr) begin errors++; $display("[TB] FAIL frame_pulse: got %b expected %b", o.ferr, e.ferr); end
        checks++; if (o.ferr2 !== 1'b0) begin errors++; $display("[TB] FAIL frame_one_cycle: got %b expected 0", o.ferr2); end
        checks++; if ({o.valid, o.data} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL frame_no_delivery: got %b/%h expected %b/%h", o.valid, o.data, e.valid, e.data); end
        checks++; if (o.perr !== 1'b0) begin errors++; $display("[TB] FAIL frame_no_parity: got %b expected 0", o.perr); end
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("[TB] FAIL frame_count: got %0d expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_glitch();
        obs_t o;
        res_t e;
        int   s0;
        s0 = perr_cnt + ferr_cnt + ovr_cnt;
        @(negedge iCLOCK);
        iPS2_DAT = 1'b0;
        iPS2_CLK = 1'b0;
        repeat (P_FILTER - 1) @(negedge iCLOCK);
        iPS2_CLK = 1'b1;
        iPS2_DAT = 1'b1;
        repeat (HALF) @(negedge iCLOCK);
        checks++; if ({oVALID, oDATA} !== {model_valid, model_data}) begin errors++; $display("[TB] FAIL glitch_outputs: got %b/%h expected %b/%h", oVALID, oDATA, model_valid, model_data); end
        checks++; if (perr_cnt + ferr_cnt + ovr_cnt - s0 !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", perr_cnt + ferr_cnt + ovr_cnt - s0); end
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL glitch_next_frame: got %b/%h expected %b/%h", o.valid, o.data, e.valid, e.data); end
        checks++; if ({o.perr, o.ferr} !== 2'b00) begin errors++; $display("[TB] FAIL glitch_next_errs: got %b expected 00", {o.perr, o.ferr}); end
    endtask

    task automatic test_timeout();
        obs_t       o;
        obs_t       dummy;
        res_t       e;
        logic [7:0] d;
        logic       found;
        int         t;
        d     = 8'hF0;
        found = 1'b0;
        t     = 0;
        ps2_bit(1'b0, 1'b0, dummy);
        for (int i = 0; i < 5; i++) ps2_bit(d[i], 1'b0, dummy);
        for (int n = 0; n < 2 * P_TIMEOUT && !found; n++) begin
            @(negedge iCLOCK);
            if (oFRAME_ERR) begin
                found = 1'b1;
                t = cyc;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL timeout_seen: got %b expected 1", found); end
        checks++; if (t - last_fall_cyc !== P_TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", t - last_fall_cyc, P_TIMEOUT + 1); end
        checks++; if ({oVALID, oDATA} !== {model_valid, model_data}) begin errors++; $display("[TB] FAIL timeout_outputs: got %b/%h expected %b/%h", oVALID, oDATA, model_valid, model_data); end
        @(negedge iCLOCK);
        checks++; if (oFRAME_ERR !== 1'b0) begin errors++; $display("[TB] FAIL timeout_one_cycle: got %b expected 0", oFRAME_ERR); end
        repeat (HALF) @(negedge iCLOCK);
        send_frame(d, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL timeout_next_frame: got %b/%h expected %b/%h", o.valid, o.data, e.valid, e.data); end
    endtask

    task automatic test_overrun();
        obs_t o;
        res_t e;
        int   v0;
        v0 = ovr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data, o.ovr} !== {e.valid, e.data, e.ovr}) begin errors++; $display("[TB] FAIL overrun_first: got %b/%h/%b expected %b/%h/%b", o.valid, o.data, o.ovr, e.valid, e.data, e.ovr); end
        send_frame(8'h32, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL overrun_data: got %b/%h expected %b/%h", o.valid, o.data, e.valid, e.data); end
        checks++; if (o.ovr !== e.ovr) begin errors++; $display("[TB] FAIL overrun_pulse: got %b expected %b", o.ovr, e.ovr); end
        checks++; if (o.ovr2 !== 1'b0) begin errors++; $display("[TB] FAIL overrun_one_cycle: got %b expected 0", o.ovr2); end
        checks++; if (ovr_cnt - v0 !== 1) begin errors++; $display("[TB] FAIL overrun_count: got %0d expected 1", ovr_cnt - v0); end
    endtask

    task automatic test_ack_same_cycle();
        obs_t o;
        res_t e;
        int   v0;
        do_ack();
        v0 = ovr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data, o.ovr} !== {e.valid, e.data, e.ovr}) begin errors++; $display("[TB] FAIL ackdel_first: got %b/%h/%b expected %b/%h/%b", o.valid, o.data, o.ovr, e.valid, e.data, e.ovr); end
        send_frame(8'h32, 1'b0, 1'b1, 1'b1, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data} !== {e.valid, e.data}) begin errors++; $display("[TB] FAIL ackdel_data: got %b/%h expected %b/%h", o.valid, o.data, e.valid, e.data); end
        checks++; if (o.ovr !== e.ovr) begin errors++; $display("[TB] FAIL ackdel_no_overrun: got %b expected %b", o.ovr, e.ovr); end
        checks++; if (ovr_cnt - v0 !== 0) begin errors++; $display("[TB] FAIL ackdel_count: got %0d expected 0", ovr_cnt - v0); end
    endtask

    task automatic test_midframe_reset(input logic use_sync, input string tag);
        obs_t       o;
        obs_t       dummy;
        res_t       e;
        logic [7:0] d;
        int         s0;
        d = 8'h1C;
        ps2_bit(1'b0, 1'b0, dummy);
        for (int i = 0; i < 4; i++) ps2_bit(d[i], 1'b0, dummy);
        repeat (2) @(negedge iCLOCK);
        if (use_sync) iRESET_SYNC = 1'b1;
        else          iRESET      = 1'b1;
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        iRESET      = 1'b0;
        model_valid = 1'b0;
        model_data  = 8'h00;
        checks++; if ({oVALID, oDATA} !== {model_valid, model_data}) begin errors++; $display("[TB] FAIL %s_outputs: got %b/%h expected %b/%h", tag, oVALID, oDATA, model_valid, model_data); end
        checks++; if ({oPARITY_ERR, oFRAME_ERR, oOVERRUN} !== 3'b000) begin errors++; $display("[TB] FAIL %s_pulses: got %b expected 000", tag, {oPARITY_ERR, oFRAME_ERR, oOVERRUN}); end
        s0 = perr_cnt + ferr_cnt + ovr_cnt;
        repeat (P_TIMEOUT + 50) @(negedge iCLOCK);
        checks++; if (perr_cnt + ferr_cnt + ovr_cnt - s0 !== 0) begin errors++; $display("[TB] FAIL %s_idle_quiet: got %0d expected 0", tag, perr_cnt + ferr_cnt + ovr_cnt - s0); end
        send_frame(d, 1'b0, 1'b1, 1'b0, o);
        e = exp_q.pop_front();
        checks++; if ({o.valid, o.data, o.ovr} !== {e.valid, e.data, e.ovr}) begin errors++; $display("[TB] FAIL %s_next_frame: got %b/%h/%b expected %b/%h/%b", tag, o.valid, o.data, o.ovr, e.valid, e.data, e.ovr); end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_receive_ack();
        test_parity_error();
        test_frame_error();
        test_glitch();
        do_ack();
        test_timeout();
        do_ack();
        test_overrun();
        test_ack_same_cycle();
        test_midframe_reset(1'b0, "async_reset");
        test_midframe_reset(1'b1, "sync_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
